// File: rtl/d_mem_sched_pkg.sv
// d_mem_sched_pkg: shared state, size and segment encodings for the data-memory scheduler.
package d_mem_sched_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        DONE  = 3'd5
    } state_t;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;
    localparam logic [2:0] KSEG0 = 3'b100;
    localparam logic [2:0] KSEG1 = 3'b101;
    typedef struct packed {
        logic        wr;
        size_e       size;
        logic [31:0] vaddr;
        logic [3:0]  wstrb;
    } slot_t;
endpackage

// File: rtl/d_mem_sched_if.sv
// d_mem_sched_if: pipeline-side request/result and SRAM-like data-port signals of the scheduler.
interface d_mem_sched_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid, req1_valid, req0_wr, req1_wr;
    logic [1:0]        req0_size, req1_size;
    logic [31:0]       req0_vaddr, req1_vaddr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata;
    logic [3:0]        req0_wstrb, req1_wstrb;
    logic              flush, stall;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_req, mem_wr, mem_no_cache, mem_addr_ok, mem_data_ok;
    logic [1:0]        mem_size;
    logic [3:0]        mem_wstrb;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [31:0]       mem_paddr;
    modport slave (
        input  req0_valid, req1_valid, req0_wr, req1_wr, req0_size, req1_size,
               req0_vaddr, req1_vaddr, req0_wdata, req1_wdata, req0_wstrb, req1_wstrb,
               flush, mem_addr_ok, mem_data_ok, mem_rdata,
        output stall, rdata0, rdata1, mem_req, mem_wr, mem_size, mem_wstrb, mem_wdata,
               mem_paddr, mem_no_cache
    );
    modport master (
        output req0_valid, req1_valid, req0_wr, req1_wr, req0_size, req1_size,
               req0_vaddr, req1_vaddr, req0_wdata, req1_wdata, req0_wstrb, req1_wstrb,
               flush, mem_addr_ok, mem_data_ok, mem_rdata,
        input  stall, rdata0, rdata1, mem_req, mem_wr, mem_size, mem_wstrb, mem_wdata,
               mem_paddr, mem_no_cache
    );
endinterface

// File: rtl/d_addr_map.sv
// d_addr_map: kseg0/kseg1 unmapped translation and the kseg1 uncached decision.
module d_addr_map
    import d_mem_sched_pkg::*;
#(
    parameter bit KSEG1_UNCACHED = 1'b1
) (
    input  logic [31:0] vaddr_i,
    output logic [31:0] paddr_o,
    output logic        no_cache_o
);
    always_comb begin
        paddr_o    = (vaddr_i[31:29] == KSEG0 || vaddr_i[31:29] == KSEG1) ? {3'b000, vaddr_i[28:0]} : vaddr_i;
        no_cache_o = KSEG1_UNCACHED && vaddr_i[31:29] == KSEG1;
    end
endmodule

// File: rtl/d_mem_sched.sv
// d_mem_sched: serialises up to two in-order data accesses onto one SRAM-like port
// and stalls the MEM stage until every accepted access has completed.
module d_mem_sched
    import d_mem_sched_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter bit KSEG1_UNCACHED = 1'b1
) (
    input logic          clk,
    input logic          resetn,
    d_mem_sched_if.slave bus
);
    state_t            state_q, state_d;
    slot_t             req_q[2], req_d[2];
    logic [DATA_W-1:0] wdata_q[2], wdata_d[2], rdata_q[2], rdata_d[2];
    logic              v1_q, v1_d, fp_q, fp_d, fin, sel, no_cache;
    logic [31:0]       paddr;

    assign sel = state_q == REQ1 || state_q == WAIT1;

    d_addr_map #(.KSEG1_UNCACHED(KSEG1_UNCACHED)) u_map (
        .vaddr_i   (req_q[sel].vaddr),
        .paddr_o   (paddr),
        .no_cache_o(no_cache)
    );

    assign bus.mem_wr       = req_q[sel].wr;
    assign bus.mem_size     = req_q[sel].size;
    assign bus.mem_wstrb    = req_q[sel].wstrb;
    assign bus.mem_wdata    = wdata_q[sel];
    assign bus.mem_paddr    = paddr;
    assign bus.mem_no_cache = no_cache;
    assign bus.rdata0       = rdata_q[0];
    assign bus.rdata1       = rdata_q[1];

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        v1_d        = v1_q;
        fp_d        = fp_q;
        fin         = 1'b0;
        bus.stall   = 1'b1;
        bus.mem_req = 1'b0;
        case (state_q)
            IDLE: begin
                bus.stall = !bus.flush && (bus.req0_valid || bus.req1_valid);
                if (bus.stall) begin
                    state_d    = bus.req0_valid ? REQ0 : REQ1;
                    req_d[0]   = '{bus.req0_wr, size_e'(bus.req0_size), bus.req0_vaddr, bus.req0_wstrb};
                    req_d[1]   = '{bus.req1_wr, size_e'(bus.req1_size), bus.req1_vaddr, bus.req1_wstrb};
                    wdata_d[0] = bus.req0_wdata;
                    wdata_d[1] = bus.req1_wdata;
                    v1_d       = bus.req1_valid;
                end
            end
            REQ0, REQ1: begin
                bus.mem_req = 1'b1;
                fp_d        = fp_q || bus.flush;
                fin         = bus.mem_addr_ok && bus.mem_data_ok;
                state_d     = bus.mem_addr_ok ? (sel ? WAIT1 : WAIT0) : state_q;
            end
            WAIT0, WAIT1: begin
                fp_d = fp_q || bus.flush;
                fin  = bus.mem_data_ok;
            end
            DONE: begin
                bus.stall = 1'b0;
                fp_d      = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a response arriving with the handshake completes the access without a WAIT cycle
        if (fin) begin
            rdata_d[sel] = req_q[sel].wr ? rdata_q[sel] : bus.mem_rdata;
            state_d      = (!sel && v1_q && !fp_d) ? REQ1 : DONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            req_q   <= '{default: '0};
            wdata_q <= '{default: '0};
            rdata_q <= '{default: '0};
            v1_q    <= 1'b0;
            fp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            v1_q    <= v1_d;
            fp_q    <= fp_d;
        end
    end
endmodule

// File: tb/tb_d_mem_sched.sv
// tb_d_mem_sched: randomized bench with an in-bench port responder and a reference
// model of address mapping, issue order, stall length and load results.
module tb_d_mem_sched;
    import d_mem_sched_pkg::*;
    typedef struct {
        bit          v;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] va;
        logic [31:0] wd;
        logic [3:0]  ws;
    } acc_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    int          total = 0;
    int          bad = 0;
    acc_t        acc[2];
    logic [31:0] exp_rd[2];

    d_mem_sched_if #(.DATA_W(32)) a ();
    d_mem_sched_if #(.DATA_W(32)) b ();

    d_mem_sched #(.DATA_W(32), .KSEG1_UNCACHED(1'b1)) dut (.clk(clk), .resetn(resetn), .bus(a));
    d_mem_sched #(.DATA_W(32), .KSEG1_UNCACHED(1'b0)) dut_c (.clk(clk), .resetn(resetn), .bus(b));

    always #5 clk = ~clk;

    function automatic logic [31:0] map_pa(logic [31:0] va);
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        return va;
    endfunction

    function automatic logic map_nc(logic [31:0] va, bit unc);
        return unc && va >= 32'hA000_0000 && va < 32'hC000_0000;
    endfunction

    function automatic acc_t mk(bit v, bit wr, logic [31:0] va, logic [31:0] wd);
        return '{v, wr, SZ_WORD, va, wd, 4'hF};
    endfunction

    task automatic drive(input bit en);
        a.req0_valid = en && acc[0].v;
        a.req1_valid = en && acc[1].v;
        a.req0_wr    = acc[0].wr;
        a.req1_wr    = acc[1].wr;
        a.req0_size  = acc[0].size;
        a.req1_size  = acc[1].size;
        a.req0_vaddr = acc[0].va;
        a.req1_vaddr = acc[1].va;
        a.req0_wdata = acc[0].wd;
        a.req1_wdata = acc[1].wd;
        a.req0_wstrb = acc[0].ws;
        a.req1_wstrb = acc[1].ws;
    endtask

    // ad: cycles mem_req waits before addr_ok; dd: cycles from handshake to data_ok (0 = same cycle)
    task automatic run(input string nm, input int ad, input int dd, input int fc, input logic [31:0] frd);
        int          order[$];
        int          iss = 0, acnt = 0, dcnt = 0, stalls = 0, cur = -1, want;
        bit          outst = 0, fin = 0;
        logic [71:0] got, exp;
        if (acc[0].v) order.push_back(0);
        if (acc[1].v && !(acc[0].v && fc >= 1 && fc <= ad + 1 + dd)) order.push_back(1);
        want = 1 + order.size() * (ad + 1 + dd);
        drive(1'b1);
        for (int c = 0; c < 300 && !fin; c++) begin
            a.flush       = (c == fc);
            a.mem_addr_ok = 1'b0;
            a.mem_data_ok = 1'b0;
            a.mem_rdata   = (frd != 0) ? frd : $urandom();
            #1;
            if (a.mem_req) begin
                total++;
                if (outst || iss >= order.size()) begin
                    bad++;
                    $display("FAIL %s unexpected_req cycle=%0d issued=%0d outstanding=%0d expected_reqs=%0d",
                             nm, c, iss, outst, order.size());
                end else begin
                    cur = order[iss];
                    got = {a.mem_wr, a.mem_size, a.mem_wstrb, a.mem_wdata, a.mem_paddr, a.mem_no_cache};
                    exp = {acc[cur].wr, acc[cur].size, acc[cur].ws, acc[cur].wd, map_pa(acc[cur].va),
                           map_nc(acc[cur].va, 1'b1)};
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL %s req_attr slot=%0d cycle=%0d got=%h exp=%h", nm, cur, c, got, exp);
                    end
                end
                if (acnt == ad) begin
                    a.mem_addr_ok = 1'b1;
                    acnt = 0;
                    iss++;
                    outst = 1;
                    dcnt = 0;
                end else acnt++;
            end else if (outst) dcnt++;
            if (outst && dcnt == dd) begin
                a.mem_data_ok = 1'b1;
                outst = 0;
                if (cur >= 0 && !acc[cur].wr) exp_rd[cur] = a.mem_rdata;
            end
            if (a.stall) stalls++;
            else begin
                fin = 1;
                drive(1'b0);
            end
            if (!fin) @(negedge clk);
        end
        a.flush = 1'b0;
        a.mem_addr_ok = 1'b0;
        a.mem_data_ok = 1'b0;
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL %s timeout stalls=%0d issued=%0d", nm, stalls, iss);
            drive(1'b0);
            resetn = 1'b0;
            #1 resetn = 1'b1;
            exp_rd = '{32'h0, 32'h0};
        end else begin
            total++;
            if (stalls != want) begin
                bad++;
                $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, stalls, want);
            end
            total++;
            if (iss != order.size()) begin
                bad++;
                $display("FAIL %s issued got=%0d exp=%0d", nm, iss, order.size());
            end
            total++;
            if (a.rdata0 !== exp_rd[0] || a.rdata1 !== exp_rd[1]) begin
                bad++;
                $display("FAIL %s rdata got=%h/%h exp=%h/%h", nm, a.rdata0, a.rdata1, exp_rd[0], exp_rd[1]);
            end
            @(negedge clk);
            #1;
            total++;
            if (a.stall !== 1'b0 || a.mem_req !== 1'b0) begin
                bad++;
                $display("FAIL %s after_done stall=%b mem_req=%b exp=0/0", nm, a.stall, a.mem_req);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        #2;
        total++;
        if (a.stall !== 1'b0 || a.mem_req !== 1'b0 || a.rdata0 !== 32'h0 || a.rdata1 !== 32'h0) begin
            bad++;
            $display("FAIL reset_state stall=%b mem_req=%b rdata=%h/%h exp=0/0/0/0", a.stall, a.mem_req, a.rdata0, a.rdata1);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (a.mem_req !== 1'b0 || b.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_release mem_req=%b/%b exp=0/0", a.mem_req, b.mem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_single_load;
        acc[0] = mk(1, 0, 32'h8000_1000, 32'h0);
        acc[1] = mk(0, 0, 32'h0, 32'h0);
        run("single_load", 0, 1, -1, 32'hDEAD_BEEF);
        total++;
        if (a.rdata0 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL single_load_rdata0 got=%h exp=deadbeef", a.rdata0);
        end
    endtask

    task automatic test_dual;
        acc[0] = mk(1, 1, 32'hA000_0010, 32'h1234_5678);
        acc[1] = mk(1, 0, 32'h9FC0_0000, 32'h0);
        run("dual", 0, 1, -1, 32'h0);
    endtask

    task automatic test_addr_delay;
        acc[0] = mk(1, 1, 32'hBFC0_0100, 32'h0BAD_F00D);
        acc[1] = mk(1, 0, 32'h0040_0000, 32'h0);
        run("addr_delay", 4, 2, -1, 32'h0);
    endtask

    task automatic test_flush;
        acc[0] = mk(1, 0, 32'h8000_0040, 32'h0);
        acc[1] = mk(1, 0, 32'h8000_0080, 32'h0);
        run("flush_wait0", 0, 2, 2, 32'h0);
    endtask

    task automatic test_same_cycle;
        acc[0] = mk(1, 0, 32'hA000_0200, 32'h0);
        acc[1] = mk(1, 0, 32'h1000_0000, 32'h0);
        run("same_cycle", 0, 0, -1, 32'h0);
    endtask

    task automatic test_idle;
        acc[0] = mk(1, 0, 32'h8000_2000, 32'h0);
        acc[1] = mk(0, 0, 32'h0, 32'h0);
        drive(1'b1);
        a.flush = 1'b1;
        #1;
        total++;
        if (a.stall !== 1'b0) begin
            bad++;
            $display("FAIL idle_flush_stall got=%b exp=0", a.stall);
        end
        @(negedge clk);
        #1;
        total++;
        if (a.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_flush_no_issue mem_req=%b exp=0", a.mem_req);
        end
        drive(1'b0);
        a.flush = 1'b0;
        a.mem_data_ok = 1'b1;
        a.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        a.mem_data_ok = 1'b0;
        #1;
        total++;
        if (a.rdata0 !== exp_rd[0] || a.rdata1 !== exp_rd[1] || a.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_data_ok_ignored rdata=%h/%h mem_req=%b exp=%h/%h/0",
                     a.rdata0, a.rdata1, a.mem_req, exp_rd[0], exp_rd[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int ad, dd, fc;
        bit v0;
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            for (int s = 0; s < 2; s++)
                acc[s] = '{1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom(), $urandom(), 4'($urandom())};
            acc[0].v = v0;
            acc[1].v = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            ad = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            fc = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(1, 12);
            run("random", ad, dd, fc, 32'h0);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            acc[0] = mk(1, 0, 32'h8000_0000 + 32'(i * 4), 32'h0);
            acc[1] = mk(1, i[0], 32'hA000_0000 + 32'(i * 8), 32'(i));
            run("back_to_back", 0, 1, -1, 32'h0);
        end
    endtask

    task automatic test_async_reset;
        acc[0] = mk(1, 0, 32'h8000_0300, 32'h0);
        acc[1] = mk(1, 0, 32'h8000_0400, 32'h0);
        drive(1'b1);
        @(negedge clk);
        a.mem_addr_ok = 1'b1;
        @(negedge clk);
        a.mem_addr_ok = 1'b0;
        a.mem_data_ok = 1'b1;
        a.mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        a.mem_data_ok = 1'b0;
        a.mem_addr_ok = 1'b1;
        @(negedge clk);
        a.mem_addr_ok = 1'b0;
        #1;
        total++;
        if (a.stall !== 1'b1 || a.mem_req !== 1'b0 || a.rdata0 !== 32'hCAFE_0001) begin
            bad++;
            $display("FAIL wait1_before_reset stall=%b mem_req=%b rdata0=%h exp=1/0/cafe0001", a.stall, a.mem_req, a.rdata0);
        end
        #1;
        resetn = 1'b0;
        drive(1'b0);
        #1;
        total++;
        if (a.stall !== 1'b0 || a.mem_req !== 1'b0 || a.rdata0 !== 32'h0 || a.rdata1 !== 32'h0) begin
            bad++;
            $display("FAIL async_reset stall=%b mem_req=%b rdata=%h/%h exp=0/0/0/0", a.stall, a.mem_req, a.rdata0, a.rdata1);
        end
        exp_rd = '{32'h0, 32'h0};
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (a.mem_req !== 1'b0 || a.stall !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle mem_req=%b stall=%b exp=0/0", a.mem_req, a.stall);
        end
        @(negedge clk);
    endtask

    task automatic test_cached_kseg1;
        b.req0_valid = 1'b1;
        b.req0_vaddr = 32'hBFC0_0000;
        @(negedge clk);
        #1;
        total++;
        if (b.mem_req !== 1'b1 || b.mem_no_cache !== map_nc(32'hBFC0_0000, 1'b0) || b.mem_paddr !== map_pa(32'hBFC0_0000)) begin
            bad++;
            $display("FAIL kseg1_cached mem_req=%b no_cache=%b paddr=%h exp=1/0/%h",
                     b.mem_req, b.mem_no_cache, b.mem_paddr, map_pa(32'hBFC0_0000));
        end
        b.mem_addr_ok = 1'b1;
        @(negedge clk);
        b.mem_addr_ok = 1'b0;
        b.mem_data_ok = 1'b1;
        b.mem_rdata = 32'h0123_4567;
        @(negedge clk);
        b.mem_data_ok = 1'b0;
        b.req0_valid = 1'b0;
        #1;
        total++;
        if (b.stall !== 1'b0 || b.rdata0 !== 32'h0123_4567) begin
            bad++;
            $display("FAIL kseg1_cached_done stall=%b rdata0=%h exp=0/01234567", b.stall, b.rdata0);
        end
        @(negedge clk);
    endtask

    initial begin
        acc[0] = mk(0, 0, 32'h0, 32'h0);
        acc[1] = mk(0, 0, 32'h0, 32'h0);
        exp_rd = '{32'h0, 32'h0};
        drive(1'b0);
        a.flush = 1'b0;
        a.mem_addr_ok = 1'b0;
        a.mem_data_ok = 1'b0;
        a.mem_rdata = 32'h0;
        {b.req0_valid, b.req1_valid, b.req0_wr, b.req1_wr, b.flush, b.mem_addr_ok, b.mem_data_ok} = '0;
        {b.req0_size, b.req1_size, b.req0_wstrb, b.req1_wstrb} = '0;
        {b.req0_vaddr, b.req1_vaddr, b.req0_wdata, b.req1_wdata, b.mem_rdata} = '0;
        test_reset();
        test_single_load();
        test_dual();
        test_addr_delay();
        test_flush();
        test_same_cycle();
        test_idle();
        test_back_to_back();
        test_random();
        test_async_reset();
        test_cached_kseg1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/d_mem_sched.md
Name: d_mem_sched

Overview:
- Scheduler for the data-memory path of the dual-issue pipeline.
- Accepts up to two data accesses per cycle, one per issue slot, in program order: slot0 older than slot1.
- Performs kseg0/kseg1 virtual-to-physical mapping and the uncached decision.
- Serialises the accesses onto the single SRAM-like data port in front of the D-cache / uncached bridge, and stalls the pipeline until all accepted accesses complete.

Parameters:
- DATA_W, 32, data width of all data buses.
- KSEG1_UNCACHED, 1, when 1 kseg1 accesses drive mem_no_cache=1; when 0 every access is cached.

Ports:
- clk  in  1  clock (only clock).
- resetn  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  slot access present.
- req0_wr / req1_wr  in  1  1=store, 0=load.
- req0_size / req1_size  in  2  0=byte, 1=half, 2=word.
- req0_vaddr / req1_vaddr  in  32  virtual address.
- req0_wdata / req1_wdata  in  DATA_W  store data.
- req0_wstrb / req1_wstrb  in  4  byte strobes.
- flush  in  1  exception/flush from the commit stage.
- stall  out  1  hold the MEM stage; request inputs must be stable while stall=1.
- rdata0 / rdata1  out  DATA_W  load results, valid in the cycle stall deasserts.
- mem_req  out  1  request to the data port.
- mem_wr, mem_size, mem_wstrb, mem_wdata  out  1/2/4/DATA_W  request attributes.
- mem_paddr  out  32  physical address.
- mem_no_cache  out  1  route access to the uncached bridge.
- mem_addr_ok  in  1  request accepted.
- mem_data_ok  in  1  response returned; write acknowledge or read data.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Address mapping:
  - vaddr[31:30]==2'b10 gives paddr={3'b0,vaddr[28:0]}; otherwise paddr=vaddr.
  - no_cache = KSEG1_UNCACHED && vaddr[31:29]==3'b101.
  - The mapping is applied to the request captured at issue time.
- Reset:
  - state=IDLE; mem_req=0; stall=0; rdata0=rdata1=0.
  - All latched request fields=0; flush_pend=0.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE:
  - If !flush and (req0_valid|req1_valid): stall=1 combinationally in this cycle.
  - Go to REQ0 if req0_valid, else REQ1.
  - If flush, stay IDLE, issue nothing, stall=0.
- REQx:
  - mem_req=1 with slot x attributes; stall=1.
  - On mem_addr_ok go to WAITx, same cycle is the handshake.
  - mem_req and its attributes must not change or drop until addr_ok.
- WAITx:
  - mem_req=0; stall=1.
  - On mem_data_ok capture mem_rdata into rdatax (loads only; stores leave rdatax unchanged).
  - From WAIT0, go to REQ1 if req1_valid && !flush_pend, else DONE.
  - From WAIT1, go to DONE.
  - If mem_addr_ok and mem_data_ok arrive in the same cycle in REQx, treat it as WAITx completing; never skip the data capture.
- DONE:
  - stall=0 for exactly one cycle so the pipeline advances; then IDLE.
  - A new request is not sampled in DONE.
  - If flush_pend is set, clear it and go to IDLE with rdata unchanged.
- Flush:
  - Flush during REQx/WAITx sets flush_pend.
  - The in-flight access always completes; no request is withdrawn after assertion.
  - Slot1 is not issued after a flush.
- Latency:
  - Single access with a zero-wait port: IDLE→REQ→WAIT→DONE = 3 cycles of stall.
  - Dual access: 5 cycles of stall.
- Ordering:
  - Strictly slot0 then slot1, even when one is cached and one is uncached.
  - At most one outstanding transaction.
- mem_data_ok outside WAIT/REQ is ignored.
- Asynchronous reset mid-transaction returns to IDLE immediately; the downstream port is reset by the same resetn.

Decomposition:
- Shared package holds:
  - state encoding constants: 3-bit, IDLE=0..DONE=5.
  - size codes.
  - KSEG segment constants: 3'b100, 3'b101.
- One sub-module, d_addr_map: combinational vaddr→{paddr,no_cache}, instantiated once on the muxed slot address.

Test Plan:
- Single load, slot0 vaddr=0x8000_1000, zero-wait port, mem_rdata=0xDEAD_BEEF → mem_paddr=0x0000_1000, mem_no_cache=0, stall high 3 cycles, rdata0=0xDEADBEEF.
- Dual access, slot0 store 0xA000_0010 wdata=0x1234_5678, slot1 load 0x9FC0_0000 → first request paddr=0x0000_0010 with no_cache=1, second paddr=0x1FC0_0000 with no_cache=0, in that order, stall 5 cycles.
- addr_ok delayed 4 cycles → mem_req and attributes held constant for all 4 cycles; no second request before data_ok.
- Flush asserted in WAIT0 with slot1 valid → slot1 never issued, slot0 data_ok consumed, DONE then IDLE, stall drops.
- Same-cycle mem_addr_ok and mem_data_ok in REQ0 → rdata0 captured, next state REQ1/DONE.
- resetn low during WAIT1 → outputs return to reset values asynchronously, state=IDLE; KSEG1_UNCACHED=0 run gives mem_no_cache=0 for 0xBFC0_0000.
